egress_queue: RTL and testbench
===============================

// Module: egress_queue
// PURPOSE
// - Per-output-port metadata FIFO between the crossbar and the host interface.
// - Stores META_WIDTH-bit packet descriptors in a circular buffer (simple_dual_port_mem).
// - Presents the head entry with a valid/ack handshake.
// - Reports occupancy, full/empty, and a saturating drop count for writes refused when full.
// PARAMETERS
// - PACKET_CNT  1024  queue depth in entries; any value >= 2, not required to be a power of 2
// - META_WIDTH  32    descriptor width in bits
// - DROP_CNT_W  16    width of the drop counter
// - AFULL_LVL   896   almost-full threshold, in entries (used only with EGRESS_AFULL_EN)
// PORTS
// - clk              in   1                         rising-edge clock
// - reset            in   1                         synchronous, active-high
// - egress_in        in   META_WIDTH                descriptor from crossbar
// - egress_in_en     in   1                         write strobe from crossbar
// - egress_in_ack    in   1                         interface consumes head entry
// - egress_out       out  META_WIDTH                head descriptor, held stable while valid
// - egress_out_valid out  1                         egress_out holds a live entry
// - count            out  $clog2(PACKET_CNT+1)      entries accepted and not yet popped
// - full             out  1                         count == PACKET_CNT
// - empty            out  1                         count == 0
// - drop_cnt         out  DROP_CNT_W                refused writes; saturates at all-ones
// - almost_full      out  1                         count >= AFULL_LVL; present only with EGRESS_AFULL_EN
// BEHAVIOUR
// - Reset: pointers=0, count=0, egress_out_valid=0, egress_out=0, full=0, empty=1, drop_cnt=0, almost_full=0.
// - Reset mid-operation discards all contents. Memory data is not cleared.
// - Write: accepted on an edge where egress_in_en=1 and full=0 (registered full, sampled before the edge).
//   - Accepted: store at wr_ptr, then wr_ptr advances.
//   - Pointer wrap: PACKET_CNT-1 -> 0 by explicit compare (no power-of-2 masking).
// - Drop: egress_in_en=1 while full=1 discards the write and increments drop_cnt.
//   - A write is dropped even if a pop happens on the same edge (no same-cycle slot reuse).
//   - drop_cnt holds at all-ones once saturated.
// - Pop: egress_in_ack=1 and egress_out_valid=1 on the same edge.
//   - egress_in_ack with egress_out_valid=0 is ignored and has no side effects.
// - Count: +1 for an accepted write, -1 for a pop, unchanged when both occur together.
//   - full, empty and almost_full are registered, decoded from the next count.
// - Memory read latency is 1 cycle. The block prefetches into a head register plus a 1-entry skid.
//   - egress_out is first-word-fall-through from the consumer's view.
// - Latency: write accepted at edge T into an empty queue -> egress_out_valid=1 after edge T+2.
// - Throughput: sustains one pop per cycle back-to-back while >= 2 entries remain. No bubbles.
// - Simultaneous write and pop while count==1: the pop drains the head. The new entry appears by the 2-cycle rule.
// - egress_out is stable and must not change while egress_out_valid=1 and no pop occurs.
// - Ordering: strict FIFO; no reordering and no duplication.
// CONFIGURATION
// - EGRESS_AFULL_EN defined: the almost_full port exists.
//   - Registered, asserted when count >= AFULL_LVL, deasserted when count < AFULL_LVL.
//   - No hysteresis.
// - EGRESS_AFULL_EN undefined: the port and its logic are absent. All other behaviour is identical.
// TESTING (PACKET_CNT=8, META_WIDTH=32, DROP_CNT_W=4, AFULL_LVL=6 unless noted)
// - Reset, then write 0xA5A5_0001 at edge T, with no ack:
//   - egress_out_valid=1 and egress_out=0xA5A5_0001 after edge T+2.
//   - count=1, empty=0.
// - Write 8 entries 0..7, then 3 more: full=1, count=8, drop_cnt=3.
//   - Draining yields exactly 0..7 in order, then empty=1.
// - Full queue, assert egress_in_en and egress_in_ack together for 1 cycle:
//   - The write is dropped and drop_cnt increments.
//   - count=7, and the next output is entry 1.
// - Pointer wrap: stream 20 writes with interleaved acks, keeping count <= 5.
//   - All 20 values emerge in order; pointers wrap past index 7 twice.
// - Back-to-back: with 8 entries queued, hold egress_in_ack=1 for 8 cycles.
//   - One pop per cycle, no bubbles, egress_out_valid=0 after the 8th pop.
// - Hold egress_in_en=1 while full for 20 cycles: drop_cnt saturates at 4'hF.
//   - Then assert reset for 1 cycle: every output returns to its reset value.
// - With EGRESS_AFULL_EN: almost_full rises on the edge count reaches 6 and falls when count drops to 5.

Source files
------------

// File: rtl/egress_queue.sv
// -----------------------------------------------------------------------------
// egress_queue
//
// Per-output-port descriptor FIFO sitting between the crossbar and the host
// interface. Descriptors are kept in a circular buffer built on a simple
// dual-port memory with a 1-cycle registered read. A head register plus a
// 1-entry skid register are prefetched from the memory so the consumer sees
// first-word-fall-through behaviour and can pop one entry per cycle with no
// bubbles.
//
// Optional feature macro: EGRESS_AFULL_EN
//   defined   -> AFULL_LVL parameter and almost_full output exist
//   undefined -> neither exists; everything else is identical
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high; discards all contents
//   egress_in        in   descriptor from crossbar
//   egress_in_en     in   write strobe from crossbar
//   egress_in_ack    in   consumer takes the head entry (ignored when not valid)
//   egress_out       out  head descriptor, stable while valid and not popped
//   egress_out_valid out  egress_out holds a live entry
//   count            out  entries accepted and not yet popped
//   full             out  count == PACKET_CNT
//   empty            out  count == 0
//   almost_full      out  count >= AFULL_LVL (EGRESS_AFULL_EN only)
//   drop_cnt         out  writes refused while full; saturates at all-ones
// -----------------------------------------------------------------------------

// Simple dual-port memory: one write port, one registered read port.
module simple_dual_port_mem #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds the last word read while idle.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

module egress_queue #(
    parameter int PACKET_CNT = 1024,
    parameter int META_WIDTH = 32,
`ifdef EGRESS_AFULL_EN
    parameter int AFULL_LVL  = 896,
`endif
    parameter int DROP_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [META_WIDTH-1:0]           egress_in,
    input  logic                            egress_in_en,
    input  logic                            egress_in_ack,
    output logic [META_WIDTH-1:0]           egress_out,
    output logic                            egress_out_valid,
    output logic [$clog2(PACKET_CNT+1)-1:0] count,
    output logic                            full,
    output logic                            empty,
`ifdef EGRESS_AFULL_EN
    output logic                            almost_full,
`endif
    output logic [DROP_CNT_W-1:0]           drop_cnt
);

    localparam int CNT_W = $clog2(PACKET_CNT + 1);
    localparam int PTR_W = $clog2(PACKET_CNT);

    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(PACKET_CNT);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(PACKET_CNT - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

    // Circular increment by explicit compare so non power-of-2 depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;   // written but not yet read out of memory
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  rd_v_q, rd_v_d;         // a memory read is landing this cycle
    logic                  head_v_q, head_v_d;
    logic [META_WIDTH-1:0] head_data_q, head_data_d;
    logic                  skid_v_q, skid_v_d;
    logic [META_WIDTH-1:0] skid_data_q, skid_data_d;
`ifdef EGRESS_AFULL_EN
    logic                  afull_q, afull_d;
    localparam logic [31:0] AFULL_THR = 32'(AFULL_LVL);
`endif

    logic                  wr_acc_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  rd_issue_s;
    logic [1:0]            occ_s;
    logic [META_WIDTH-1:0] rd_data_s;

    // Handshake decode and prefetch read scheduling.
    always_comb begin
        wr_acc_s = egress_in_en & ~full_q;
        drop_s   = egress_in_en & full_q;
        pop_s    = egress_in_ack & head_v_q;
        occ_s    = {1'b0, head_v_q} + {1'b0, skid_v_q} + {1'b0, rd_v_q};
        // Issue a read only if head+skid can still absorb it after this
        // cycle's pop; this keeps at most two entries outside the memory.
        if ((mem_cnt_q != {CNT_W{1'b0}}) && ((occ_s - {1'b0, pop_s}) < 2'd2)) begin
            rd_issue_s = 1'b1;
        end else begin
            rd_issue_s = 1'b0;
        end
    end

    simple_dual_port_mem #(
        .DEPTH  (PACKET_CNT),
        .WIDTH  (META_WIDTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s & ~reset),
        .wr_addr (wr_ptr_q),
        .wr_data (egress_in),
        .rd_en   (rd_issue_s & ~reset),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

    // Pointers, occupancy counters and status flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_cnt_d  = mem_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_acc_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_issue_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (wr_acc_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_acc_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        if (wr_acc_s && !rd_issue_s) begin
            mem_cnt_d = mem_cnt_q + CNT_ONE;
        end else if (!wr_acc_s && rd_issue_s) begin
            mem_cnt_d = mem_cnt_q - CNT_ONE;
        end else begin
            mem_cnt_d = mem_cnt_q;
        end

        if (drop_s && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + DROP_ONE;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == {CNT_W{1'b0}});
`ifdef EGRESS_AFULL_EN
        afull_d = ({{(32-CNT_W){1'b0}}, count_d} >= AFULL_THR);
`endif
    end

    // Head/skid refill: head takes skid first, then the landing read.
    always_comb begin
        rd_v_d      = rd_issue_s;
        head_v_d    = head_v_q;
        head_data_d = head_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;

        if (!head_v_q || pop_s) begin
            if (skid_v_q) begin
                head_v_d    = 1'b1;
                head_data_d = skid_data_q;
                if (rd_v_q) begin
                    skid_v_d    = 1'b1;
                    skid_data_d = rd_data_s;
                end else begin
                    skid_v_d = 1'b0;
                end
            end else if (rd_v_q) begin
                head_v_d    = 1'b1;
                head_data_d = rd_data_s;
                skid_v_d    = 1'b0;
            end else begin
                head_v_d = 1'b0;
            end
        end else begin
            // Head is held; a landing read parks in the (then empty) skid.
            if (rd_v_q) begin
                skid_v_d    = 1'b1;
                skid_data_d = rd_data_s;
            end else begin
                skid_v_d = skid_v_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            mem_cnt_q   <= {CNT_W{1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            drop_cnt_q  <= {DROP_CNT_W{1'b0}};
            rd_v_q      <= 1'b0;
            head_v_q    <= 1'b0;
            head_data_q <= {META_WIDTH{1'b0}};
            skid_v_q    <= 1'b0;
            skid_data_q <= {META_WIDTH{1'b0}};
`ifdef EGRESS_AFULL_EN
            afull_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_cnt_q   <= mem_cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_v_q      <= rd_v_d;
            head_v_q    <= head_v_d;
            head_data_q <= head_data_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
`ifdef EGRESS_AFULL_EN
            afull_q     <= afull_d;
`endif
        end
    end

    assign egress_out       = head_data_q;
    assign egress_out_valid = head_v_q;
    assign count            = count_q;
    assign full             = full_q;
    assign empty            = empty_q;
    assign drop_cnt         = drop_cnt_q;
`ifdef EGRESS_AFULL_EN
    assign almost_full      = afull_q;
`endif

endmodule

// File: tb/tb_egress_queue.sv
// -----------------------------------------------------------------------------
// Testbench for egress_queue (PACKET_CNT=8, META_WIDTH=32, DROP_CNT_W=4,
// AFULL_LVL=6 when EGRESS_AFULL_EN is defined). Stimulus pushes every
// descriptor it expects to be accepted into exp_q; a forked monitor pops
// and compares on each cycle where egress_out_valid and egress_in_ack are
// both high, and also checks that the head is held while not popped.
// -----------------------------------------------------------------------------
module tb_egress_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] egress_in;
    logic        egress_in_en;
    logic        egress_in_ack;
    logic [31:0] egress_out;
    logic        egress_out_valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [3:0]  drop_cnt;
`ifdef EGRESS_AFULL_EN
    logic        almost_full;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    egress_queue #(
        .PACKET_CNT (8),
        .META_WIDTH (32),
`ifdef EGRESS_AFULL_EN
        .AFULL_LVL  (6),
`endif
        .DROP_CNT_W (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .egress_in        (egress_in),
        .egress_in_en     (egress_in_en),
        .egress_in_ack    (egress_in_ack),
        .egress_out       (egress_out),
        .egress_out_valid (egress_out_valid),
        .count            (count),
        .full             (full),
        .empty            (empty),
`ifdef EGRESS_AFULL_EN
        .almost_full      (almost_full),
`endif
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        logic        hold_v;
        logic [31:0] hold_d;
        logic [31:0] e;
        hold_v = 1'b0;
        hold_d = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("head_held_valid", {31'h0, egress_out_valid}, 32'h1);
                    chk("head_held_data", egress_out, hold_d);
                end
                if (egress_out_valid && egress_in_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%08h, expected no entry", egress_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fifo_data", egress_out, e);
                    end
                end
                hold_v = egress_out_valid && !egress_in_ack;
                hold_d = egress_out;
            end
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        egress_in_en  = 1'b0;
        egress_in_ack = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, {31'h0, egress_out_valid}, 32'h0);
        chk({tag, "_out"}, egress_out, 32'h0);
        chk({tag, "_count"}, {28'h0, count}, 32'h0);
        chk({tag, "_full"}, {31'h0, full}, 32'h0);
        chk({tag, "_empty"}, {31'h0, empty}, 32'h1);
        chk({tag, "_drop"}, {28'h0, drop_cnt}, 32'h0);
`ifdef EGRESS_AFULL_EN
        chk({tag, "_afull"}, {31'h0, almost_full}, 32'h0);
`endif
    endtask

    // n consecutive writes of base+i; the first n_accept are expected to land.
    task automatic write_burst(input logic [31:0] base, input int n, input int n_accept);
        for (int i = 0; i < n; i++) begin
            egress_in    = base + 32'(i);
            egress_in_en = 1'b1;
            if (i < n_accept) begin
                exp_q.push_back(base + 32'(i));
            end
            tick();
        end
        egress_in_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        egress_in_ack = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (exp_q.size() == 0) begin
                break;
            end
        end
        egress_in_ack = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        egress_in     = 32'h0;
        egress_in_en  = 1'b0;
        egress_in_ack = 1'b0;
        fork
            monitor_loop();
        join_none
        tick();
        do_reset();
        check_reset_state("rst0");

        // Ack with nothing valid: no side effects.
        egress_in_ack = 1'b1;
        tick();
        tick();
        egress_in_ack = 1'b0;
        chk("idle_ack_count", {28'h0, count}, 32'h0);
        chk("idle_ack_empty", {31'h0, empty}, 32'h1);
        chk("idle_ack_valid", {31'h0, egress_out_valid}, 32'h0);

        // Latency: write at edge T, valid only after T+2.
        egress_in    = 32'hA5A5_0001;
        egress_in_en = 1'b1;
        exp_q.push_back(32'hA5A5_0001);
        tick();
        egress_in_en = 1'b0;
        chk("lat_T_valid", {31'h0, egress_out_valid}, 32'h0);
        chk("lat_T_count", {28'h0, count}, 32'h1);
        chk("lat_T_empty", {31'h0, empty}, 32'h0);
        tick();
        chk("lat_T1_valid", {31'h0, egress_out_valid}, 32'h0);
        tick();
        chk("lat_T2_valid", {31'h0, egress_out_valid}, 32'h1);
        chk("lat_T2_out", egress_out, 32'hA5A5_0001);
        drain(10);
        chk("lat_empty", {31'h0, empty}, 32'h1);

        // Fill 0..7, three more dropped.
        write_burst(32'h0, 11, 8);
        chk("fill_full", {31'h0, full}, 32'h1);
        chk("fill_count", {28'h0, count}, 32'h8);
        chk("fill_drop", {28'h0, drop_cnt}, 32'h3);
        tick();
        tick();
        // Back-to-back: 8 pops on 8 consecutive edges.
        egress_in_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_valid", {31'h0, egress_out_valid}, 32'h1);
            tick();
        end
        egress_in_ack = 1'b0;
        chk("b2b_valid_end", {31'h0, egress_out_valid}, 32'h0);
        chk("b2b_left", 32'(exp_q.size()), 32'h0);
        chk("b2b_empty", {31'h0, empty}, 32'h1);
        chk("b2b_count", {28'h0, count}, 32'h0);

        // Full queue: write and pop on the same edge -> write dropped.
        write_burst(32'h10, 8, 8);
        tick();
        tick();
        chk("fp_full_before", {31'h0, full}, 32'h1);
        egress_in     = 32'hDEAD_BEEF;
        egress_in_en  = 1'b1;
        egress_in_ack = 1'b1;
        tick();
        egress_in_en  = 1'b0;
        egress_in_ack = 1'b0;
        chk("fp_drop", {28'h0, drop_cnt}, 32'h4);
        chk("fp_count", {28'h0, count}, 32'h7);
        chk("fp_full", {31'h0, full}, 32'h0);
        chk("fp_next_valid", {31'h0, egress_out_valid}, 32'h1);
        chk("fp_next_out", egress_out, 32'h11);
        drain(20);

`ifdef EGRESS_AFULL_EN
        write_burst(32'h400, 5, 5);
        chk("af_at5", {31'h0, almost_full}, 32'h0);
        write_burst(32'h405, 1, 1);
        chk("af_at6", {31'h0, almost_full}, 32'h1);
        egress_in_ack = 1'b1;
        tick();
        egress_in_ack = 1'b0;
        chk("af_back5_count", {28'h0, count}, 32'h5);
        chk("af_back5", {31'h0, almost_full}, 32'h0);
        drain(20);
`endif

        // Pointer wrap: 20 writes with continuous acks, occupancy stays low.
        egress_in_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            egress_in    = 32'h100 + 32'(i);
            egress_in_en = 1'b1;
            exp_q.push_back(32'h100 + 32'(i));
            tick();
            chk("wrap_count_le5", {31'h0, (count <= 4'd5)}, 32'h1);
        end
        egress_in_en = 1'b0;
        drain(20);
        chk("wrap_empty", {31'h0, empty}, 32'h1);

        // Saturation: 8 accepted, then 20 dropped (4 + 20 saturates at 15).
        write_burst(32'h200, 28, 8);
        chk("sat_drop", {28'h0, drop_cnt}, 32'hF);
        chk("sat_full", {31'h0, full}, 32'h1);
        chk("sat_count", {28'h0, count}, 32'h8);
        do_reset();
        check_reset_state("rst1");

        // Still functional after mid-operation reset.
        write_burst(32'h300, 1, 1);
        drain(10);
        chk("post_rst_empty", {31'h0, empty}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
